bsg_fifo_packet_gearbox: RTL
============================

Name: bsg_fifo_packet_gearbox

Overview:
- Bidirectional width converter between the 32-bit AXI-Lite FIFO slot interface and the 128-bit manycore packet links.
- Tx path:
  - Consumes the word stream that the host writes into a transmit FIFO slot.
  - Concatenates every words_per_packet_p words into one packet for the manycore link.
- Rx path:
  - Accepts one packet from the manycore link.
  - Serializes it into words for the host receive FIFO slot.
- One instance per FIFO slot pair (request or response).

Parameters:
- word_width_p, 32, width of one FIFO word.
- words_per_packet_p, 4, words per packet; must be at least 2.
- packet_width_lp, word_width_p*words_per_packet_p, packet width (derived, not overridable).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- tx_v_i  in  1  word valid from tx FIFO slot
- tx_data_i  in  word_width_p  word from tx FIFO slot
- tx_ready_o  out  1  word accepted when tx_v_i & tx_ready_o
- packet_v_o  out  1  assembled packet valid
- packet_o  out  packet_width_lp  assembled packet
- packet_ready_i  in  1  downstream accepts packet when packet_v_o & packet_ready_i
- packet_v_i  in  1  incoming packet valid
- packet_i  in  packet_width_lp  incoming packet
- packet_ready_o  out  1  incoming packet accepted when packet_v_i & packet_ready_o
- rx_v_o  out  1  word valid to rx FIFO slot
- rx_data_o  out  word_width_p  word to rx FIFO slot
- rx_ready_i  in  1  rx FIFO slot accepts word when rx_v_o & rx_ready_i
- tx_word_cnt_o  out  clog2(words_per_packet_p)  words collected toward the current tx packet
- rx_busy_o  out  1  rx path holds an unfinished packet

Behaviour:
- Clock and reset:
  - One clock.
  - reset_i is synchronous, active-high.
  - Reset values: tx_word_cnt_o=0, packet_v_o=0, rx_v_o=0, rx_busy_o=0, tx_ready_o=1, packet_ready_o=1.
  - Data registers are not reset. packet_o and rx_data_o are don't-care while their valid is low.
- Tx path, state machine TX_COLLECT / TX_FULL:
  - Word k of a packet is stored at packet bits [k*word_width_p +: word_width_p]; word 0 is the least significant.
  - TX_COLLECT:
    - tx_ready_o=1.
    - Each accepted word is written to slot cnt, then cnt increments.
    - Accepting the word at cnt==words_per_packet_p-1 moves to TX_FULL and resets cnt to 0.
    - packet_v_o rises the cycle after the last word is accepted (1-cycle latency).
  - TX_FULL:
    - packet_v_o=1; packet_o is held stable until the packet is accepted.
    - tx_ready_o = packet_ready_i (pass-through).
    - If the packet is accepted and a word is accepted in the same cycle, that word goes to slot 0, cnt becomes 1, and the state returns to TX_COLLECT. No bubble.
    - If the packet is accepted with no word, return to TX_COLLECT with cnt=0.
  - tx_word_cnt_o = cnt.
- Rx path, state machine RX_IDLE / RX_DRAIN:
  - RX_IDLE:
    - packet_ready_o=1, rx_v_o=0.
    - Accepting a packet registers it, sets idx=0, and moves to RX_DRAIN.
    - rx_v_o rises the next cycle.
  - RX_DRAIN:
    - rx_v_o=1; rx_data_o = packet word idx.
    - Each handshake increments idx.
    - packet_ready_o = (idx==words_per_packet_p-1) & rx_ready_i.
    - On the last-word handshake:
      - If packet_v_i is high, load the new packet and set idx=0, staying in RX_DRAIN. This gives back-to-back packets with no bubble.
      - Otherwise go to RX_IDLE.
  - rx_busy_o = (state==RX_DRAIN).
- Independence and stalls:
  - The tx and rx paths are fully independent, and simultaneous activity on both is legal.
  - A deasserted ready holds all state and data stable. There is no timeout.
- Reset mid-operation: partially collected tx words and undrained rx words are discarded, and no packet or word is emitted afterwards.
- Any word_width_p that is a multiple of 8 is legal.
- Simulation-only assertion: words_per_packet_p>=2; fatal otherwise.

Test Plan:
- Tx assembly: with packet_ready_i=1, send words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - Required: packet_v_o=1 exactly one cycle after the 4th word.
  - Required: packet_o=0x44444444_33333333_22222222_11111111.
  - Required: tx_word_cnt_o steps 1,2,3,0.
- Tx backpressure:
  - Hold packet_ready_i=0 for 5 cycles after assembly. Required: packet_o stays stable, tx_ready_o=0, and an offered word 0xAAAA0000 is not consumed.
  - Then raise packet_ready_i. Required: the packet is consumed and 0xAAAA0000 is taken as slot 0 in the same cycle; cnt=1.
- Rx drain: offer packet 0xDDDD0004_CCCC0003_BBBB0002_AAAA0001 with rx_ready_i=1.
  - Required: rx_data_o=0xAAAA0001, 0xBBBB0002, 0xCCCC0003, 0xDDDD0004 on 4 consecutive cycles, starting one cycle after acceptance.
  - Required: packet_ready_o=0 from the cycle after acceptance until the cycle of the last-word handshake.
- Rx back-to-back with stall:
  - Offer two packets continuously and toggle rx_ready_i 1,0,1,0,...
  - Required: 8 words in order with no loss or duplication.
  - Required: the second packet is accepted in the cycle of the 4th-word handshake.
- Concurrent tx/rx under random valid/ready: 100 packets each way, checked against a scoreboard. Required: zero mismatches.
- Mid-operation reset:
  - Assert reset_i after 2 tx words and 1 rx word. Required: cnt=0, rx_v_o=0, packet_v_o=0 next cycle.
  - Then send 4 fresh tx words. Required: only the 4 fresh words appear in the next packet.

Source files
------------

// File: rtl/bsg_fifo_packet_gearbox_if.sv
// Handshake bundle between a 32-bit FIFO slot pair and a manycore packet link.
// slave is the gearbox side, master is the FIFO/link environment side.
interface bsg_fifo_packet_gearbox_if #(
    parameter int word_width_p       = 32,
    parameter int words_per_packet_p = 4
);
    localparam int packet_width_lp = word_width_p * words_per_packet_p;
    localparam int cnt_width_lp    = $clog2(words_per_packet_p);

    // tx: words in, packets out
    logic                       tx_v_i;
    logic [word_width_p-1:0]    tx_data_i;
    logic                       tx_ready_o;
    logic                       packet_v_o;
    logic [packet_width_lp-1:0] packet_o;
    logic                       packet_ready_i;

    // rx: packets in, words out
    logic                       packet_v_i;
    logic [packet_width_lp-1:0] packet_i;
    logic                       packet_ready_o;
    logic                       rx_v_o;
    logic [word_width_p-1:0]    rx_data_o;
    logic                       rx_ready_i;

    // status
    logic [cnt_width_lp-1:0]    tx_word_cnt_o;
    logic                       rx_busy_o;

    modport slave (
        input  tx_v_i, tx_data_i, packet_ready_i, packet_v_i, packet_i, rx_ready_i,
        output tx_ready_o, packet_v_o, packet_o, packet_ready_o, rx_v_o, rx_data_o,
               tx_word_cnt_o, rx_busy_o
    );

    modport master (
        output tx_v_i, tx_data_i, packet_ready_i, packet_v_i, packet_i, rx_ready_i,
        input  tx_ready_o, packet_v_o, packet_o, packet_ready_o, rx_v_o, rx_data_o,
               tx_word_cnt_o, rx_busy_o
    );
endinterface

// File: rtl/bsg_fifo_packet_gearbox.sv
// Word <-> packet gearbox: tx packs words_per_packet_p words into a packet
// (word 0 least significant), rx serializes a packet back into words.
module bsg_fifo_packet_gearbox #(
    parameter int word_width_p       = 32,
    parameter int words_per_packet_p = 4
) (
    input logic                        clk_i,
    input logic                        reset_i,
    bsg_fifo_packet_gearbox_if.slave   io
);
    localparam int packet_width_lp = word_width_p * words_per_packet_p;
    localparam int cnt_width_lp    = $clog2(words_per_packet_p);
    localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(words_per_packet_p - 1);

    // ---------------- tx path ----------------
    typedef enum logic {TX_COLLECT, TX_FULL} tx_state_e;

    tx_state_e                  tx_state_r, tx_state_n;
    logic [cnt_width_lp-1:0]    tx_cnt_r;
    logic [packet_width_lp-1:0] tx_packet_r;
    logic                       tx_ready, tx_packet_v, tx_accept;

    assign tx_accept = io.tx_v_i & tx_ready;

    // tx state register
    always_ff @(posedge clk_i) begin
        if (reset_i) tx_state_r <= TX_COLLECT;
        else         tx_state_r <= tx_state_n;
    end

    // tx next state: full after the last word, back to collecting once the packet leaves
    always_comb begin
        tx_state_n = tx_state_r;
        case (tx_state_r)
            TX_COLLECT: if (tx_accept && (tx_cnt_r == last_idx_lp)) tx_state_n = TX_FULL;
            TX_FULL:    if (io.packet_ready_i)                       tx_state_n = TX_COLLECT;
            default:    tx_state_n = TX_COLLECT;
        endcase
    end

    // tx outputs: while full, a word may only enter in the cycle the packet drains
    always_comb begin
        tx_ready    = 1'b1;
        tx_packet_v = 1'b0;
        if (tx_state_r == TX_FULL) begin
            tx_ready    = io.packet_ready_i;
            tx_packet_v = 1'b1;
        end
    end

    // tx word counter; it is already 0 in TX_FULL so a word taken there lands in slot 0
    always_ff @(posedge clk_i) begin
        if (reset_i)        tx_cnt_r <= '0;
        else if (tx_accept) tx_cnt_r <= (tx_cnt_r == last_idx_lp) ? '0 : tx_cnt_r + 1'b1;
    end

    // tx packet assembly register
    always_ff @(posedge clk_i) begin
        if (tx_accept) tx_packet_r[tx_cnt_r*word_width_p +: word_width_p] <= io.tx_data_i;
    end

    assign io.tx_ready_o    = tx_ready;
    assign io.packet_v_o    = tx_packet_v;
    assign io.packet_o      = tx_packet_r;
    assign io.tx_word_cnt_o = tx_cnt_r;

    // ---------------- rx path ----------------
    typedef enum logic {RX_IDLE, RX_DRAIN} rx_state_e;

    rx_state_e                  rx_state_r, rx_state_n;
    logic [cnt_width_lp-1:0]    rx_idx_r;
    logic [packet_width_lp-1:0] rx_packet_r;
    logic                       rx_v, rx_packet_ready, rx_load, rx_word_hs;

    assign rx_load    = io.packet_v_i & rx_packet_ready;
    assign rx_word_hs = rx_v & io.rx_ready_i;

    // rx state register
    always_ff @(posedge clk_i) begin
        if (reset_i) rx_state_r <= RX_IDLE;
        else         rx_state_r <= rx_state_n;
    end

    // rx next state: stay draining when a new packet arrives on the last word
    always_comb begin
        rx_state_n = rx_state_r;
        case (rx_state_r)
            RX_IDLE:  if (rx_load) rx_state_n = RX_DRAIN;
            RX_DRAIN: if (rx_word_hs && (rx_idx_r == last_idx_lp) && !rx_load) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    // rx outputs: next packet accepted only together with the last-word handshake
    always_comb begin
        rx_v            = 1'b0;
        rx_packet_ready = 1'b1;
        if (rx_state_r == RX_DRAIN) begin
            rx_v            = 1'b1;
            rx_packet_ready = (rx_idx_r == last_idx_lp) & io.rx_ready_i;
        end
    end

    // rx word index; a load restarts the sequence
    always_ff @(posedge clk_i) begin
        if (reset_i)         rx_idx_r <= '0;
        else if (rx_load)    rx_idx_r <= '0;
        else if (rx_word_hs) rx_idx_r <= (rx_idx_r == last_idx_lp) ? '0 : rx_idx_r + 1'b1;
    end

    // rx packet holding register
    always_ff @(posedge clk_i) begin
        if (rx_load) rx_packet_r <= io.packet_i;
    end

    assign io.rx_v_o         = rx_v;
    assign io.rx_data_o      = rx_packet_r[rx_idx_r*word_width_p +: word_width_p];
    assign io.packet_ready_o = rx_packet_ready;
    assign io.rx_busy_o      = rx_v;

    // parameter sanity check
    always_ff @(posedge clk_i) begin
        assert (words_per_packet_p >= 2)
            else $fatal(1, "bsg_fifo_packet_gearbox: words_per_packet_p must be >= 2");
    end
endmodule
